// File: rtl/tft_lcd_bus_ctrl.sv
// tft_lcd_bus_ctrl
// Avalon-MM slave that queues command/data words (tagged with RS) in a small
// FIFO and replays them as 8080-style write cycles on the LCD pins with
// programmable setup, strobe-low and hold times.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | CS released, waiting for the FIFO to hold a word
// SETUP  | CS low, data/RS valid, WR still high for T_SETUP cycles
// STROBE | WR held low for T_WR_LOW cycles
// HOLD   | WR back high, data/RS held for T_HOLD cycles before next word
module tft_lcd_bus_ctrl #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int T_SETUP    = 1,
    parameter int T_WR_LOW   = 2,
    parameter int T_HOLD     = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic              read_n,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic              waitrequest,
    output logic              lcd_cs_n,
    output logic              lcd_rs,
    output logic              lcd_wr_n,
    output logic              lcd_rd_n,
    output logic [DATA_W-1:0] lcd_data
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int AW1   = AW + 1;
    localparam int T_SW  = (T_SETUP > T_WR_LOW) ? T_SETUP : T_WR_LOW;
    localparam int T_MAX = (T_SW > T_HOLD) ? T_SW : T_HOLD;
    localparam int CW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    localparam logic [CW-1:0]  CNT_SETUP = CW'(T_SETUP - 1);
    localparam logic [CW-1:0]  CNT_WR    = CW'(T_WR_LOW - 1);
    localparam logic [CW-1:0]  CNT_HOLD  = CW'(T_HOLD - 1);
    localparam logic [AW1-1:0] DEPTH_C   = AW1'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    state_t            state, state_nx;
    logic [CW-1:0]     cnt, cnt_nx;
    logic              cs_nx, wr_nx, rs_nx;
    logic [DATA_W-1:0] data_nx;

    logic [DATA_W:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW1-1:0]    fifo_cnt;
    logic              full, empty, push, pop, flush, busy;

    // Reads are never stalled and carry no side effects, so the strobe is not needed.
    logic unused_read_n;
    assign unused_read_n = read_n;

    assign full        = (fifo_cnt == DEPTH_C);
    assign empty       = (fifo_cnt == '0);
    assign busy        = (state != IDLE);
    assign waitrequest = chipselect & ~write_n & ~address[1] & full;
    assign push        = chipselect & ~write_n & ~address[1] & ~full;
    assign flush       = chipselect & ~write_n & (address == 2'd3) & writedata[0];
    assign readdata    = (address == 2'd2) ? {{(DATA_W-3){1'b0}}, empty, full, busy} : '0;
    assign lcd_rd_n    = 1'b1;

    // FIFO storage: RS tag in the top bit, taken from address bit 0.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {address[0], writedata};
    end

    // FIFO pointers and occupancy; flush clears the queue but not the pins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
            else if (pop && !push) fifo_cnt <= fifo_cnt - 1'b1;
        end
    end

    // Sequencer state, timing counter and registered LCD pins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            lcd_cs_n <= 1'b1;
            lcd_wr_n <= 1'b1;
            lcd_rs   <= 1'b0;
            lcd_data <= '0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            lcd_cs_n <= cs_nx;
            lcd_wr_n <= wr_nx;
            lcd_rs   <= rs_nx;
            lcd_data <= data_nx;
        end
    end

    // Next-state logic: a pop loads the pins, otherwise the counter walks each phase down.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        cs_nx    = lcd_cs_n;
        wr_nx    = lcd_wr_n;
        rs_nx    = lcd_rs;
        data_nx  = lcd_data;
        pop      = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop               = 1'b1;
                    {rs_nx, data_nx}  = fifo_mem[rd_ptr];
                    cs_nx             = 1'b0;
                    cnt_nx            = CNT_SETUP;
                    state_nx          = SETUP;
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    wr_nx    = 1'b0;
                    cnt_nx   = CNT_WR;
                    state_nx = STROBE;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            STROBE: begin
                if (cnt == '0) begin
                    wr_nx    = 1'b1;
                    cnt_nx   = CNT_HOLD;
                    state_nx = HOLD;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    if (!empty) begin
                        pop              = 1'b1;
                        {rs_nx, data_nx} = fifo_mem[rd_ptr];
                        cnt_nx           = CNT_SETUP;
                        state_nx         = SETUP;
                    end else begin
                        cs_nx    = 1'b1;
                        state_nx = IDLE;
                    end
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_tft_lcd_bus_ctrl.sv
// tb_tft_lcd_bus_ctrl
// Drives Avalon writes/reads into the LCD bus controller and checks the LCD
// pin activity against a cycle-level reference model of word start times.
// Non-default timing is used so that every phase counter actually counts.
`timescale 1ns/1ps
module tb_tft_lcd_bus_ctrl;

    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int TS    = 2;
    localparam int TW    = 3;
    localparam int TH    = 2;
    localparam int P     = TS + TW + TH;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [1:0]    address = 2'd0;
    logic          chipselect = 1'b0;
    logic          write_n = 1'b1;
    logic          read_n = 1'b1;
    logic [DW-1:0] writedata = '0;
    logic [DW-1:0] readdata;
    logic          waitrequest;
    logic          lcd_cs_n, lcd_rs, lcd_wr_n, lcd_rd_n;
    logic [DW-1:0] lcd_data;

    tft_lcd_bus_ctrl #(
        .DATA_W(DW), .FIFO_DEPTH(DEPTH), .T_SETUP(TS), .T_WR_LOW(TW), .T_HOLD(TH)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .read_n(read_n), .writedata(writedata), .readdata(readdata),
        .waitrequest(waitrequest), .lcd_cs_n(lcd_cs_n), .lcd_rs(lcd_rs),
        .lcd_wr_n(lcd_wr_n), .lcd_rd_n(lcd_rd_n), .lcd_data(lcd_data)
    );

    always #5 clk = ~clk;

    // cyc = number of rising edges seen so far; stimulus runs between edges.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic          rs;
        logic [DW-1:0] data;
        int            acc;
        int            start;
    } word_t;

    word_t sb[$];
    int    starts[$];
    int    last_start = 0;
    bit    have_last = 0;
    int    n_checks = 0;
    int    n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Words accepted but not yet popped into the sequencer during cycle c.
    function automatic int model_occ(int c);
        int n = 0;
        foreach (sb[i]) if (sb[i].acc <= c && sb[i].start > c) n++;
        return n;
    endfunction

    // A word occupies the pins from its pop edge until P edges later.
    function automatic bit model_busy(int c);
        foreach (starts[i]) if (starts[i] <= c && c < starts[i] + P) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [2:0] model_status(int c);
        int o;
        o = model_occ(c);
        return {o == 0, o == DEPTH, model_busy(c)};
    endfunction

    task automatic bus_idle();
        chipselect = 1'b0;
        write_n    = 1'b1;
        read_n     = 1'b1;
    endtask

    task automatic read_status(input string name, input logic [2:0] exp);
        chipselect = 1'b1;
        write_n    = 1'b1;
        read_n     = 1'b0;
        address    = 2'd2;
        #1;
        chk(name, readdata, {{(DW-3){1'b0}}, exp});
    endtask

    // Called just after a falling edge; returns just after the next falling edge following acceptance.
    task automatic bus_write(input logic [1:0] addr, input logic [DW-1:0] d);
        int    tries;
        bit    exp_wait;
        int    a, s, f;
        word_t w;
        tries      = 0;
        exp_wait   = 1'b0;
        address    = addr;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        read_n     = 1'b1;
        forever begin
            #1;
            exp_wait = !addr[1] && (model_occ(cyc) == DEPTH);
            chk("waitrequest", waitrequest, exp_wait);
            if (!exp_wait) break;
            tries++;
            if (tries > 100) begin
                n_checks++;
                n_fail++;
                $display("FAIL write_timeout: waitrequest still high after %0d cycles, required release", tries);
                break;
            end
            @(negedge clk);
        end
        if (!exp_wait) begin
            if (!addr[1]) begin
                a = cyc + 1;
                s = (have_last && a < last_start + P) ? last_start + P : a + 1;
                w.rs = addr[0]; w.data = d; w.acc = a; w.start = s;
                sb.push_back(w);
                starts.push_back(s);
                last_start = s;
                have_last  = 1'b1;
                while (starts.size() > 1 && starts[0] + P < cyc) void'(starts.pop_front());
            end else if (addr == 2'd3 && d[0]) begin
                f = cyc + 1;
                while (sb.size() > 0 && sb[sb.size()-1].start > f) void'(sb.pop_back());
                while (starts.size() > 0 && starts[starts.size()-1] > f) void'(starts.pop_back());
                if (starts.size() > 0) last_start = starts[starts.size()-1];
                else have_last = 1'b0;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || model_busy(cyc)) && n < 400) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n >= 400) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d words still pending, required 0", sb.size());
        end
        @(negedge clk);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: every WR falling edge consumes one expected word; phase widths are measured.
    logic          prev_cs = 1'b1, prev_wr = 1'b1;
    int            t_wr_fall = 0, t_wr_rise = 0;
    logic [DW:0]   held = '0;
    word_t         mon_w;
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_cs = 1'b1;
            prev_wr = 1'b1;
        end else begin
            if (prev_wr && !lcd_wr_n) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_word: got rs=%0d data=%h, required no transfer", lcd_rs, lcd_data);
                end else begin
                    mon_w = sb.pop_front();
                    chk("lcd_word", {lcd_rs, lcd_data}, {mon_w.rs, mon_w.data});
                    chk("wr_fall_cycle", cyc, mon_w.start + TS);
                    chk("cs_low_at_wr", lcd_cs_n, 1'b0);
                    chk("rd_n_high", lcd_rd_n, 1'b1);
                end
                held      = {lcd_rs, lcd_data};
                t_wr_fall = cyc;
            end
            if (!prev_wr && lcd_wr_n) begin
                chk("wr_low_width", cyc - t_wr_fall, TW);
                chk("data_held_wr", {lcd_rs, lcd_data}, held);
                t_wr_rise = cyc;
            end
            if (!prev_cs && lcd_cs_n) begin
                chk("cs_hold", cyc - t_wr_rise, TH);
                chk("data_held_cs", {lcd_rs, lcd_data}, held);
                chk("wr_high_at_cs", lcd_wr_n, 1'b1);
            end
            prev_cs = lcd_cs_n;
            prev_wr = lcd_wr_n;
        end
    end

    logic [15:0] data_tab [5] = '{16'h0022, 16'h1111, 16'h2222, 16'h3333, 16'h4444};
    int          s0;
    int          op;

    initial begin
        bus_idle();
        repeat (3) @(negedge clk);
        #1;
        chk("rst_cs_n", lcd_cs_n, 1'b1);
        chk("rst_wr_n", lcd_wr_n, 1'b1);
        chk("rst_rd_n", lcd_rd_n, 1'b1);
        chk("rst_rs", lcd_rs, 1'b0);
        chk("rst_data", lcd_data, 16'h0);
        read_status("rst_status", 3'b100);
        @(negedge clk);
        reset_n = 1'b1;
        bus_idle();
        @(negedge clk);

        // single command word
        bus_write(2'd0, 16'h0022);
        bus_idle();
        wait_drain();
        read_status("status_after_single", 3'b100);

        // command + four data words back-to-back, then a sixth while full
        for (int i = 0; i < 5; i++) bus_write((i == 0) ? 2'd0 : 2'd1, data_tab[i]);
        read_status("status_full", 3'b011);
        bus_write(2'd1, 16'h5555);
        bus_idle();
        wait_drain();
        read_status("status_after_burst", 3'b100);

        // flush while the first of three words is strobing
        bus_write(2'd0, 16'h00AA);
        s0 = sb[0].start;
        bus_write(2'd1, 16'h00BB);
        bus_write(2'd1, 16'h00CC);
        wait_until(s0 + TS + 1);
        bus_write(2'd3, 16'h0001);
        bus_idle();
        wait_drain();
        read_status("status_after_flush", 3'b100);
        address = 2'd3; #1; chk("read_addr3", readdata, 16'h0);
        address = 2'd0; #1; chk("read_addr0", readdata, 16'h0);
        @(negedge clk);

        // asynchronous reset in the middle of a strobe
        bus_write(2'd1, 16'hBEEF);
        bus_idle();
        s0 = sb[0].start;
        wait_until(s0 + TS + 1);
        #2;
        chk("pre_rst_wr_low", lcd_wr_n, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("async_rst_wr_n", lcd_wr_n, 1'b1);
        chk("async_rst_cs_n", lcd_cs_n, 1'b1);
        chk("async_rst_data", lcd_data, 16'h0);
        chk("async_rst_rs", lcd_rs, 1'b0);
        sb.delete();
        starts.delete();
        have_last = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (12) @(negedge clk);
        read_status("status_after_reset", 3'b100);
        @(negedge clk);

        // randomized traffic against the model
        for (int k = 0; k < 300; k++) begin
            op = $urandom_range(0, 11);
            if (op <= 5) begin
                bus_write(2'($urandom_range(0, 1)), 16'($urandom));
            end else if (op <= 7) begin
                bus_idle();
                repeat ($urandom_range(1, 8)) @(negedge clk);
            end else if (op == 8) begin
                bus_write(2'd3, 16'($urandom));
            end else if (op == 9) begin
                bus_write(2'd2, 16'($urandom));
            end else begin
                read_status("status_random", model_status(cyc));
                @(negedge clk);
            end
        end
        bus_idle();
        wait_drain();
        read_status("status_final", 3'b100);
        bus_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
